// File: rtl/sc_pkg.sv
// sc_pkg: shared types and constants for the stochastic multiply controller.
//   state_t   : controller FSM states
//   lfsr_taps : Fibonacci feedback mask for a maximal-length LFSR of width 4..16
//   DEF_SEED_*: default LFSR seeds
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DEF_SEED_A = 16'h0001;
    localparam logic [15:0] DEF_SEED_B = 16'h00A5;

    // Bit i of the mask feeds state[i] into the XOR that becomes the new bit 0.
    // Each mask encodes a primitive polynomial, so the register cycles through
    // all 2^w-1 nonzero states.
    function automatic logic [15:0] lfsr_taps(input int w);
        logic [15:0] m;
        case (w)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: Fibonacci shift-left LFSR used as a stochastic number generator.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, loads SEED
//   load  : reload SEED (start of an operation)
//   en    : advance one state
//   state : current LFSR state, never zero
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
    // The all-zero state is a lockup state, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= SEED_NZ;
        end else if (en) begin
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

endmodule

// File: rtl/sc_mult_controller.sv
// sc_mult_controller: accepts two unsigned operands, runs two SNG bitstreams
// for one full LFSR period, ANDs them and returns the count of ones.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready, a/b : operand handshake
//   out_valid/out_ready, result : result handshake (result held until taken)
//   z_stream             : live product bit, 0 outside RUN
module sc_mult_controller
    import sc_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] SEED_A = WIDTH'(DEF_SEED_A),
    parameter logic [WIDTH-1:0] SEED_B = WIDTH'(DEF_SEED_B)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z_stream
);

    // Cycle count of the last RUN cycle: L-1 = 2^WIDTH - 2.
    localparam logic [WIDTH-1:0] LAST = WIDTH'((1 << WIDTH) - 2);

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lfsr_a, lfsr_b;
    logic             accept;
    logic             running;
    logic             x, y, z;

    // in_ready is high exactly while IDLE, so this is the accept strobe.
    assign accept  = in_valid & in_ready;
    assign running = (state == RUN);

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
        .clk(clk), .rst(rst), .load(accept), .en(running), .state(lfsr_a)
    );

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
        .clk(clk), .rst(rst), .load(accept), .en(running), .state(lfsr_b)
    );

    // LFSR states span 1..L, so '<=' yields exactly k ones for operand k.
    assign x        = (lfsr_a <= a_reg);
    assign y        = (lfsr_b <= b_reg);
    assign z        = x & y;
    assign z_stream = z & running;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            ones      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        ones     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    ones <= ones + WIDTH'(z);
                    cnt  <= cnt + WIDTH'(1);
                    if (cnt == LAST) begin
                        // Fold in the final product bit on the way out.
                        result    <= ones + WIDTH'(z);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
